// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared types and geometry helpers for the CNN stream blocks
package cnn_pkg;

  // Collector control states; COLLECT runs until the final raster beat is taken
  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } coll_state_e;

  // Valid output dimension of a KxK window slid over an n-pixel axis
  function automatic int out_dim(input int n, input int k);
    return n - k + 1;
  endfunction

  // Counter width for values 0..n-1, never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Write address width for the kept feature map
  function automatic int addr_width(input int w, input int h, input int k);
    return cnt_width(out_dim(w, k) * out_dim(h, k));
  endfunction

endpackage

// File: rtl/raster_counter.sv
// rtl/raster_counter.sv - col/row raster position counter with wrap, clear and last-pixel flag
module raster_counter #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int CW    = 5,
  parameter int RW    = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [CW-1:0] o_col,
  output logic [RW-1:0] o_row,
  output logic          o_last
);

  localparam logic [CW-1:0] L_COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] L_ROW_MAX = RW'(IMG_H - 1);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          w_col_wrap;
  logic          w_row_wrap;

  assign w_col_wrap = (r_col == L_COL_MAX);
  assign w_row_wrap = (r_row == L_ROW_MAX);

  // Advance one pixel per enabled beat; column wrap steps the row, final pixel wraps both
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_clr) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_en) begin
      if (w_col_wrap) begin
        r_col <= '0;
        r_row <= w_row_wrap ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign o_col  = r_col;
  assign o_row  = r_row;
  assign o_last = w_col_wrap && w_row_wrap;

endmodule

// File: rtl/conv_output_collector.sv
// rtl/conv_output_collector.sv - drops KxK border beats and writes kept pixels to result RAM; CONV_COLLECT_RELU_EN adds inline ReLU
module conv_output_collector
  import cnn_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int K      = 3,
  parameter int ADDR_W = addr_width(IMG_W, IMG_H, K)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              data_valid,
  output logic              busy,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_data,
  output logic              frame_done
);

  localparam int CW = cnt_width(IMG_W);
  localparam int RW = cnt_width(IMG_H);
  localparam logic [CW-1:0] L_COL_MIN = CW'(K - 1);
  localparam logic [RW-1:0] L_ROW_MIN = RW'(K - 1);

  coll_state_e r_state;
  coll_state_e w_next_state;

  logic [CW-1:0]     w_col;
  logic [RW-1:0]     w_row;
  logic              w_last;
  logic              w_accept;
  logic              w_keep;
  logic              w_clear;
  logic [WIDTH-1:0]  w_pix;

  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] r_addr_next;
  logic [WIDTH-1:0]  r_wr_data;
  logic              r_frame_done;

  assign w_accept = (r_state == COLLECT) && data_valid;
  assign w_clear  = (r_state == IDLE) && start;
  assign w_keep   = w_accept && (w_col >= L_COL_MIN) && (w_row >= L_ROW_MIN);

`ifdef CONV_COLLECT_RELU_EN
  assign w_pix = data_in[WIDTH-1] ? '0 : data_in;
`else
  assign w_pix = data_in;
`endif

  raster_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .CW    (CW),
    .RW    (RW)
  ) u_raster (
    .clk    (clk),
    .rst_n  (reset),
    .i_clr  (w_clear),
    .i_en   (w_accept),
    .o_col  (w_col),
    .o_row  (w_row),
    .o_last (w_last)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state: arm on start, leave as the final raster beat is accepted
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start)             w_next_state = COLLECT;
      COLLECT: if (w_accept && w_last) w_next_state = IDLE;
      default:                        w_next_state = IDLE;
    endcase
  end

  // Write port: one-cycle registered write of each kept beat, sequential addresses per frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_addr_next  <= '0;
      r_wr_data    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_wr_en      <= w_keep;
      r_frame_done <= w_accept && w_last;
      if (w_clear) begin
        r_addr_next <= '0;
      end else if (w_keep) begin
        r_wr_addr   <= r_addr_next;
        r_addr_next <= r_addr_next + 1'b1;
        r_wr_data   <= w_pix;
      end
    end
  end

  assign busy       = (r_state == COLLECT);
  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_conv_output_collector.sv
// tb/tb_conv_output_collector.sv - scoreboard bench for conv_output_collector against a raster-arithmetic model
module tb_conv_output_collector;

  localparam int WIDTH = 8;
  localparam int W     = 4;
  localparam int H     = 4;
  localparam int K     = 3;
  localparam int OW    = W - K + 1;
  localparam int AW    = 2;

  logic             clk;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             busy;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             frame_done;

  typedef struct {
    int addr;
    int data;
    bit done;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  bit   m_active = 1'b0;
  int   m_n = 0;

  conv_output_collector #(
    .WIDTH  (WIDTH),
    .IMG_W  (W),
    .IMG_H  (H),
    .K      (K),
    .ADDR_W (AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .data_in    (data_in),
    .data_valid (data_valid),
    .busy       (busy),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int relu(input int d);
`ifdef CONV_COLLECT_RELU_EN
    return (d >= 128) ? 0 : d;
`else
    return d;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // One clock of stimulus; the model decides what the coming edge does to the frame
  task automatic cyc(input bit st, input bit v, input int d);
    int col;
    int row;
    @(posedge clk);
    #1;
    chk("busy", int'(busy), int'(m_active));
    start      = st;
    data_valid = v;
    data_in    = WIDTH'(d);
    if (m_active && v) begin
      col = m_n % W;
      row = m_n / W;
      if (col >= K - 1 && row >= K - 1)
        q.push_back('{addr: (row - (K - 1)) * OW + (col - (K - 1)),
                      data: relu(d & 8'hFF),
                      done: (m_n == W * H - 1)});
      if (m_n == W * H - 1) m_active = 1'b0;
      else m_n++;
    end else if (!m_active && st) begin
      m_active = 1'b1;
      m_n      = 0;
    end
  endtask

  // mode 0: data=base+n; 1: 3-cycle gaps after beats 5 and 12; 2: random data and gaps; 3: ReLU probes
  task automatic frame(input int base, input int mode);
    int d;
    cyc(1'b1, 1'b0, 0);
    for (int n = 0; n < W * H; n++) begin
      d = base + n;
      if (mode == 2) d = int'($urandom_range(0, 255));
      if (mode == 3) d = (n == 10) ? 8'hFB : (n == 11) ? 8'h05 : (n == 14) ? 8'h80 : n;
      cyc(1'b0, 1'b1, d);
      if (mode == 1 && (n == 5 || n == 12))
        repeat (3) cyc(1'b0, 1'b0, 8'hEE);
      if (mode == 2 && n != W * H - 1 && $urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) cyc(1'($urandom_range(0, 1)), 1'b0, 8'hEE);
    end
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_wr_en"}, int'(wr_en), 0);
    chk({tag, "_wr_addr"}, int'(wr_addr), 0);
    chk({tag, "_wr_data"}, int'(wr_data), 0);
    chk({tag, "_frame_done"}, int'(frame_done), 0);
  endtask

  // Monitor: every write must match the head of the expectation queue
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (wr_en) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write addr=%0d data=%0d required=no_write", wr_addr, wr_data);
        end else begin
          e = q.pop_front();
          if (int'(wr_addr) != e.addr || int'(wr_data) != e.data || frame_done != e.done) begin
            bad++;
            $display("FAIL write actual=(%0d,%0d,done=%0b) required=(%0d,%0d,done=%0b)",
                     wr_addr, wr_data, frame_done, e.addr, e.data, e.done);
          end
          if (frame_done && busy) begin
            bad++;
            $display("FAIL busy_at_done actual=1 required=0");
          end
        end
      end else if (frame_done) begin
        total++;
        bad++;
        $display("FAIL stray_frame_done actual=1 required=0");
      end
    end
  end

  initial begin
    int guard;
    reset      = 1'b0;
    start      = 1'b0;
    data_valid = 1'b0;
    data_in    = '0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    reset = 1'b1;

    // basic frame, then gapped frame
    frame(0, 0);
    repeat (2) cyc(1'b0, 1'b0, 0);
    frame(0, 1);
    repeat (2) cyc(1'b0, 1'b0, 0);

    // valid beats before start, start coincident with a valid beat
    repeat (5) cyc(1'b0, 1'b1, 8'h77);
    cyc(1'b1, 1'b1, 8'h99);
    for (int n = 0; n < W * H; n++) cyc(1'b0, 1'b1, 200 + n);
    repeat (2) cyc(1'b0, 1'b0, 0);

    // reset mid-frame after 8 beats
    cyc(1'b1, 1'b0, 0);
    for (int n = 0; n < 8; n++) cyc(1'b0, 1'b1, n);
    @(posedge clk);
    #1;
    reset      = 1'b0;
    data_valid = 1'b0;
    start      = 1'b0;
    m_active   = 1'b0;
    q.delete();
    #1;
    check_quiet("midreset");
    repeat (2) @(posedge clk);
    #1;
    check_quiet("midreset_hold");
    reset = 1'b1;
    frame(0, 0);

    // back-to-back: start lands in the frame_done cycle
    frame(100, 0);
    repeat (2) cyc(1'b0, 1'b0, 0);

    // ReLU probes
    frame(0, 3);
    repeat (2) cyc(1'b0, 1'b0, 0);

    // randomized frames with random gaps and ignored starts
    for (int f = 0; f < 6; f++) begin
      frame(0, 2);
      repeat ($urandom_range(0, 2)) cyc(1'b0, 1'b0, 0);
    end

    guard = 0;
    while (q.size() != 0 && guard < 20) begin
      cyc(1'b0, 1'b0, 0);
      guard++;
    end
    repeat (2) cyc(1'b0, 1'b0, 0);
    chk("queue_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
